// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : FIFO controller that stores words in an external
//                single-write / single-read RAM with a fixed read latency.
//                A small output buffer absorbs RAM read returns, so the
//                downstream side sees a plain valid/ready stream while the
//                RAM pipeline keeps running.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        data word width
//    DEPTH        external RAM words (power of 2, >= 4)
//    RAM_LATENCY  RAM read latency in cycles (>= 1)
//    OBUF_DEPTH   output buffer entries (>= RAM_LATENCY + 1)
//
//  Ports
//    clk          clock
//    s_rst_n      synchronous active-low reset
//    in_data      upstream push data
//    in_vld       upstream push valid
//    in_rdy       upstream push ready (independent of out_rdy)
//    out_data     oldest buffered word
//    out_vld      output buffer not empty
//    out_rdy      downstream pop ready
//    ram_wr_en    RAM write enable
//    ram_wr_add   RAM write address
//    ram_wr_data  RAM write data
//    ram_rd_en    RAM read enable
//    ram_rd_add   RAM read address
//    ram_rd_data  RAM read data, valid RAM_LATENCY cycles after ram_rd_en
//    level        words held: RAM + reads in flight + output buffer
//
//  Build option
//    RAM_FIFO_CTRL_BYPASS_EN  when defined, a word pushed into an otherwise
//                             drained block goes straight into the output
//                             buffer and skips the RAM round trip.
// ============================================================================

`default_nettype none

module ram_fifo_ctrl #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 512,
    parameter int RAM_LATENCY = 1,
    parameter int OBUF_DEPTH  = RAM_LATENCY + 1
) (
    input  logic                               clk,
    input  logic                               s_rst_n,
    // upstream push
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_vld,
    output logic                               in_rdy,
    // downstream pop
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_vld,
    input  logic                               out_rdy,
    // RAM write port
    output logic                               ram_wr_en,
    output logic [$clog2(DEPTH)-1:0]           ram_wr_add,
    output logic [WIDTH-1:0]                   ram_wr_data,
    // RAM read port
    output logic                               ram_rd_en,
    output logic [$clog2(DEPTH)-1:0]           ram_rd_add,
    input  logic [WIDTH-1:0]                   ram_rd_data,
    // occupancy
    output logic [$clog2(DEPTH+OBUF_DEPTH):0]  level
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int c_ADDR_W   = $clog2(DEPTH);
    localparam int c_RCNT_W   = c_ADDR_W + 1;
    localparam int c_LVL_W    = $clog2(DEPTH + OBUF_DEPTH) + 1;
    localparam int c_IF_W     = $clog2(RAM_LATENCY + 1);
    localparam int c_OBP_W    = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int c_OBC_W    = $clog2(OBUF_DEPTH + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // r_run is cleared by reset and set on the first clock after release, so
    // in_rdy rises exactly one cycle after s_rst_n goes high.
    logic                     r_run;

    logic [c_ADDR_W-1:0]      r_wr_ptr;
    logic [c_ADDR_W-1:0]      r_rd_ptr;
    // Words written to RAM and not yet read-issued. Because it is registered,
    // a word written this cycle is not counted until next cycle, which makes
    // it read-eligible one cycle after its write and keeps read and write
    // from ever touching the same address in the same cycle.
    logic [c_RCNT_W-1:0]      r_ram_cnt;

    // One bit per issued read, shifted along until its data returns.
    logic [RAM_LATENCY-1:0]   r_rd_pipe;
    logic [c_IF_W-1:0]        r_inflight;

    logic [WIDTH-1:0]         r_obuf_mem [OBUF_DEPTH];
    logic [c_OBP_W-1:0]       r_ob_wp;
    logic [c_OBP_W-1:0]       r_ob_rp;
    logic [c_OBC_W-1:0]       r_obuf_cnt;

    // ------------------------------------------------------------------------
    // Handshake and control decode
    // ------------------------------------------------------------------------
    logic                     w_in_rdy;
    logic                     w_push;
    logic                     w_bypass;
    logic                     w_ram_wr;
    logic                     w_pop;
    logic                     w_rd;
    logic                     w_ret;
    logic                     w_ob_wr;
    logic [WIDTH-1:0]         w_ob_wdata;
    logic [c_LVL_W-1:0]       w_credit_used;
    logic [c_LVL_W-1:0]       w_level;

    // in_rdy looks only at RAM occupancy, never at out_rdy.
    assign w_in_rdy = s_rst_n & r_run & (r_ram_cnt < c_RCNT_W'(DEPTH));
    assign w_push   = in_vld & w_in_rdy;

`ifdef RAM_FIFO_CTRL_BYPASS_EN
    // Only bypass when nothing older is anywhere in the RAM path; otherwise
    // the bypassed word could overtake words still waiting in RAM or in
    // flight, breaking ordering.
    assign w_bypass = w_push
                    & (r_ram_cnt == '0)
                    & (r_inflight == '0)
                    & (r_obuf_cnt < c_OBC_W'(OBUF_DEPTH));
`else
    assign w_bypass = 1'b0;
`endif

    assign w_ram_wr = w_push & ~w_bypass;
    assign w_pop    = s_rst_n & (r_obuf_cnt != '0) & out_rdy;

    // Read credit: every issued read owns an output buffer entry from issue
    // until it is popped. A word popped this cycle releases its entry before
    // any read issued now can return, so it is credited back immediately;
    // without that, a full-rate stream would stall every other cycle.
    assign w_credit_used = c_LVL_W'(r_inflight)
                         + c_LVL_W'(r_obuf_cnt)
                         - c_LVL_W'(w_pop);

    assign w_rd = s_rst_n
                & (r_ram_cnt != '0)
                & (w_credit_used < c_LVL_W'(OBUF_DEPTH));

    // The oldest issued read returns when its marker reaches the last stage.
    assign w_ret      = s_rst_n & r_rd_pipe[RAM_LATENCY-1];
    assign w_ob_wr    = w_ret | w_bypass;
    // Bypass and RAM return are exclusive: bypass requires zero in flight.
    assign w_ob_wdata = w_bypass ? in_data : ram_rd_data;

    assign w_level = c_LVL_W'(r_ram_cnt)
                   + c_LVL_W'(r_inflight)
                   + c_LVL_W'(r_obuf_cnt);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_rdy      = w_in_rdy;
    assign ram_wr_en   = w_ram_wr;
    assign ram_wr_add  = r_wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_en   = w_rd;
    assign ram_rd_add  = r_rd_ptr;
    assign out_vld     = s_rst_n & (r_obuf_cnt != '0);
    assign out_data    = r_obuf_mem[r_ob_rp];
    assign level       = s_rst_n ? w_level : '0;

    // ------------------------------------------------------------------------
    // RAM pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_run     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            // DEPTH is a power of two, so natural overflow wraps DEPTH-1 -> 0.
            if (w_ram_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_ram_cnt <= r_ram_cnt + c_RCNT_W'(w_ram_wr) - c_RCNT_W'(w_rd);
        end
    end

    // ------------------------------------------------------------------------
    // Read return tracking
    // ------------------------------------------------------------------------
    generate
        if (RAM_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (!s_rst_n) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= w_rd;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (!s_rst_n) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= {r_rd_pipe[RAM_LATENCY-2:0], w_rd};
                end
            end
        end
    endgenerate

    // Reset clears every marker, so returns of reads issued before reset
    // are never written into the buffer.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + c_IF_W'(w_rd) - c_IF_W'(w_ret);
        end
    end

    // ------------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_ob_wp    <= '0;
            r_ob_rp    <= '0;
            r_obuf_cnt <= '0;
        end else begin
            // OBUF_DEPTH need not be a power of two, so wrap explicitly.
            if (w_ob_wr) begin
                r_ob_wp <= (r_ob_wp == c_OBP_W'(OBUF_DEPTH - 1)) ? '0
                                                                 : r_ob_wp + c_OBP_W'(1);
            end
            if (w_pop) begin
                r_ob_rp <= (r_ob_rp == c_OBP_W'(OBUF_DEPTH - 1)) ? '0
                                                                 : r_ob_rp + c_OBP_W'(1);
            end
            r_obuf_cnt <= r_obuf_cnt + c_OBC_W'(w_ob_wr) - c_OBC_W'(w_pop);
        end
    end

    // Storage needs no reset; validity is carried by r_obuf_cnt.
    always_ff @(posedge clk) begin
        if (w_ob_wr) begin
            r_obuf_mem[r_ob_wp] <= w_ob_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none

module tb_ram_fifo_ctrl;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 4;
    localparam int RAM_LATENCY = 3;
    localparam int OBUF_DEPTH  = 4;
    localparam int AW          = $clog2(DEPTH);
    localparam int LW          = $clog2(DEPTH + OBUF_DEPTH) + 1;

`ifdef RAM_FIFO_CTRL_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam int EXP_RD  = 0;
`else
    localparam int EXP_LAT = RAM_LATENCY + 2;
    localparam int EXP_RD  = 2;
`endif

    logic             clk;
    logic             s_rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             out_rdy;
    logic             ram_wr_en;
    logic [AW-1:0]    ram_wr_add;
    logic [WIDTH-1:0] ram_wr_data;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_rd_add;
    logic [WIDTH-1:0] ram_rd_data;
    logic [LW-1:0]    level;

    ram_fifo_ctrl #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RAM_LATENCY (RAM_LATENCY),
        .OBUF_DEPTH  (OBUF_DEPTH)
    ) u_dut (
        .clk         (clk),
        .s_rst_n     (s_rst_n),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_add  (ram_wr_add),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_add  (ram_rd_add),
        .ram_rd_data (ram_rd_data),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM model with RAM_LATENCY read pipeline.
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] rd_pipe [RAM_LATENCY];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_add] <= ram_wr_data;
        if (ram_rd_en) rd_pipe[0] <= mem[ram_rd_add];
        for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[RAM_LATENCY-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and per-cycle samples.
    logic [WIDTH-1:0] q [$];
    int               g_cyc = 0;
    int               n_acc, n_pop, n_rd, first_pop, last_pop;
    logic             s_in_rdy, s_out_vld, s_wr_en, s_rd_en;
    logic [WIDTH-1:0] s_out_data, last_pop_data;
    logic [LW-1:0]    s_level;

    // One clock cycle: sample at the falling edge, score handshakes, then
    // return just after the next rising edge so the caller can drive inputs.
    task automatic tick();
        @(negedge clk);
        g_cyc++;
        s_in_rdy   = in_rdy;
        s_out_vld  = out_vld;
        s_out_data = out_data;
        s_wr_en    = ram_wr_en;
        s_rd_en    = ram_rd_en;
        s_level    = level;
        if (ram_rd_en) n_rd++;
        check("level", 32'(level), 32'(q.size()));
        if (out_vld) begin
            check("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                check("out_data", out_data, q[0]);
                if (out_rdy) begin
                    last_pop_data = q.pop_front();
                    if (n_pop == 0) first_pop = g_cyc;
                    last_pop = g_cyc;
                    n_pop++;
                end
            end
        end
        if (in_vld && in_rdy) begin
            q.push_back(in_data);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int vld_cnt;

        s_rst_n = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'hDEAD;
        out_rdy = 1'b0;
        n_acc = 0; n_pop = 0; n_rd = 0; first_pop = 0; last_pop = 0;
        @(posedge clk);
        #1;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_in_rdy",  32'(s_in_rdy),  32'd0);
        check("rst_out_vld", 32'(s_out_vld), 32'd0);
        check("rst_wr_en",   32'(s_wr_en),   32'd0);
        check("rst_rd_en",   32'(s_rd_en),   32'd0);
        check("rst_level",   32'(s_level),   32'd0);

        // ---- release: in_rdy one cycle later ----
        s_rst_n = 1'b1;
        in_vld  = 1'b0;
        tick();
        check("rel_in_rdy0", 32'(s_in_rdy), 32'd0);
        tick();
        check("rel_in_rdy1", 32'(s_in_rdy), 32'd1);

        // ---- first-word latency ----
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_data = 32'hA5;
        tick();
        in_vld = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s_out_vld && lat < 0) begin
                lat = k;
                check("lat_data", s_out_data, 32'hA5);
            end
        end
        check("latency",   32'(lat),     32'(EXP_LAT));
        check("lat_level", 32'(s_level), 32'd0);

        // ---- fill with out_rdy low: RAM + buffer capacity ----
        out_rdy = 1'b0;
        n_acc   = 0;
        in_vld  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 32'h100 + 32'(n_acc);
            tick();
        end
        check("fill_acc",    32'(n_acc),    32'd8);
        check("fill_in_rdy", 32'(s_in_rdy), 32'd0);
        check("fill_level",  32'(s_level),  32'd8);

        // ---- drain, finishing the 10-word push ----
        out_rdy = 1'b1;
        n_pop   = 0;
        for (int k = 0; k < 40 && n_pop < 10; k++) begin
            in_vld  = (n_acc < 10);
            in_data = 32'h100 + 32'(n_acc);
            tick();
        end
        in_vld = 1'b0;
        tick();
        check("drain_acc",   32'(n_acc),     32'd10);
        check("drain_pops",  32'(n_pop),     32'd10);
        check("drain_last",  last_pop_data,  32'h109);
        check("drain_level", 32'(s_level),   32'd0);
        check("drain_vld",   32'(s_out_vld), 32'd0);

        // ---- continuous stream of 3*DEPTH words ----
        n_acc = 0;
        n_pop = 0;
        in_vld = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            in_data = 32'h200 + 32'(k);
            tick();
        end
        in_vld = 1'b0;
        for (int k = 0; k < 30 && n_pop < 3 * DEPTH; k++) tick();
        check("stream_acc",  32'(n_acc),              32'(3 * DEPTH));
        check("stream_pops", 32'(n_pop),              32'(3 * DEPTH));
        check("stream_span", 32'(last_pop - first_pop), 32'(3 * DEPTH - 1));
        check("stream_last", last_pop_data,           32'h200 + 32'(3 * DEPTH - 1));

        // ---- reset with reads in flight ----
        tick();
        out_rdy = 1'b0;
        n_rd    = 0;
        in_vld  = 1'b1;
        in_data = 32'h300;
        tick();
        in_data = 32'h301;
        tick();
        in_vld = 1'b0;
        tick();
        check("flight_rd", 32'(n_rd), 32'(EXP_RD));
        s_rst_n = 1'b0;
        q.delete();
        tick();
        s_rst_n = 1'b1;
        tick();
        out_rdy = 1'b1;
        vld_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_out_vld) vld_cnt++;
        end
        check("flight_vld",   32'(vld_cnt), 32'd0);
        check("flight_level", 32'(s_level), 32'd0);

        // ---- random traffic, 10k words ----
        n_acc = 0;
        n_pop = 0;
        for (int k = 0; k < 60000 && n_pop < 10000; k++) begin
            in_vld  = (n_acc < 10000) && ($urandom_range(0, 9) < 7);
            in_data = $urandom;
            out_rdy = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_vld = 1'b0;
        tick();
        check("rand_acc",   32'(n_acc),   32'd10000);
        check("rand_pops",  32'(n_pop),   32'd10000);
        check("rand_level", 32'(s_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data word width.
REQ-002 The block SHALL have parameter DEPTH, default 512: RAM words, power of 2, >=4.
REQ-003 The block SHALL have parameter RAM_LATENCY, default 1: external RAM read latency, >=1.
REQ-004 The block SHALL have parameter OBUF_DEPTH, default RAM_LATENCY+1: output buffer entries, >=RAM_LATENCY+1.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port s_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have ports in_data, in_vld and in_rdy: in_data input WIDTH bits, in_vld input 1 bit, in_rdy output 1 bit; together the upstream valid/ready push.
REQ-008 The block SHALL have ports out_data, out_vld and out_rdy: out_data output WIDTH bits, out_vld output 1 bit, out_rdy input 1 bit; together the downstream valid/ready pop.
REQ-009 The block SHALL have ports ram_wr_en, ram_wr_add and ram_wr_data: ram_wr_en output 1 bit, ram_wr_add output $clog2(DEPTH) bits, ram_wr_data output WIDTH bits; together the RAM write port.
REQ-010 The block SHALL have ports ram_rd_en and ram_rd_add: ram_rd_en output 1 bit, ram_rd_add output $clog2(DEPTH) bits; together the RAM read port.
REQ-011 The block SHALL have port ram_rd_data, input, WIDTH bits: read data valid RAM_LATENCY cycles after ram_rd_en.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH+OBUF_DEPTH)+1 bits: total words held (RAM + in flight + buffer).

Function
REQ-013 Push: a word SHALL be accepted when in_vld & in_rdy; ram_wr_en = in_vld & in_rdy combinationally, ram_wr_add = wr_ptr, ram_wr_data = in_data.
REQ-014 in_rdy SHALL be 1 iff ram_cnt < DEPTH, with ram_cnt = words written to RAM and not yet read-issued; in_rdy SHALL have no combinational dependency on out_rdy.
REQ-015 A RAM word SHALL become read-eligible the cycle after its write: no same-cycle read/write to one address, so the RAM conflict policy is irrelevant.
REQ-016 ram_rd_en SHALL assert when eligible count > 0 and inflight + obuf_cnt < OBUF_DEPTH (credit rule); ram_rd_add = rd_ptr.
REQ-017 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0.
REQ-018 A delay line of RAM_LATENCY stages SHALL track issued reads; each return SHALL be written into the output FIFO (OBUF_DEPTH entries) in issue order.
REQ-019 out_vld SHALL be 1 iff obuf_cnt > 0; out_data SHALL be the oldest buffer entry and held stable while out_vld & !out_rdy.
REQ-020 Latency without bypass SHALL be: push in cycle 0 -> out_vld in cycle RAM_LATENCY+2 on an empty block.
REQ-021 Throughput SHALL be 1 word/cycle sustained when out_rdy = 1.
REQ-022 A simultaneous push and pop SHALL leave level unchanged.
REQ-023 Buffer full with out_rdy = 0 SHALL stall reads (no drop); RAM full SHALL deassert in_rdy.

Reset
REQ-024 While s_rst_n = 0, the block SHALL clear pointers, counters, inflight line and buffer count, and drive in_rdy=0, out_vld=0, ram_wr_en=0, ram_rd_en=0, level=0.
REQ-025 in_rdy SHALL rise the cycle after reset release; out_data SHALL be don't-care while out_vld = 0.
REQ-026 Reset mid-operation SHALL discard all data, including RAM returns still in flight.

Configuration
REQ-027 Macro RAM_FIFO_CTRL_BYPASS_EN defined: when ram_cnt=0, inflight=0 and obuf_cnt<OBUF_DEPTH, an accepted word SHALL go directly into the output buffer (no RAM write) and out_vld SHALL assert the next cycle.
REQ-028 Macro RAM_FIFO_CTRL_BYPASS_EN undefined: every word SHALL pass through the RAM and REQ-020 latency SHALL apply; ordering SHALL be preserved in both builds.

Verification
REQ-029 RAM_LATENCY=3, push 0xA5 into an empty block, out_rdy=1 -> out_data=0xA5 with out_vld in cycle 5 (cycle 1 with bypass).
REQ-030 DEPTH=4, OBUF_DEPTH=4, out_rdy=0, push 10 words -> in_rdy low after 8 accepted; level=8; no word lost.
REQ-031 Then out_rdy=1 -> words popped 0..9 in order, level back to 0, out_vld=0.
REQ-032 Continuous push and pop for 3*DEPTH words -> pointers wrap, 1 word/cycle after fill, data order intact.
REQ-033 s_rst_n pulsed low with 2 reads in flight -> out_vld=0 and level=0 after reset; no stale data emitted.
REQ-034 Random in_vld/out_rdy, 10k words, RAM_LATENCY in {1,2,4} -> scoreboard match, level equals model.
